// File: rtl/irq_pend_latch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | irq_pend_latch                                                       |
// | Sync + edge-detect raw requests into sticky, maskable pending bits.  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module irq_pend_latch #(
  parameter int N           = 8,
  parameter int CW          = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req_in,
  input  logic          mask_we,
  input  logic [N-1:0]  mask_wdata,
  input  logic          ack,
  input  logic [CW-1:0] ack_code,
  input  logic          lost_clr,
  output logic [N-1:0]  pend,
  output logic          irq,
  output logic [N-1:0]  mask,
  output logic [N-1:0]  lost
);

  logic [N-1:0] r_sync [SYNC_STAGES];
  logic [N-1:0] r_prev;
  logic [N-1:0] r_pend_raw;
  logic [N-1:0] r_mask;
  logic [N-1:0] r_lost;

  logic [N-1:0] w_rise;
  logic [N-1:0] w_ack_vec;
  logic [N-1:0] w_pend_raw_nxt;
  logic [N-1:0] w_lost_nxt;

  // Codes at or above N match no bit and are therefore ignored.
  always_comb begin
    w_ack_vec = '0;
    if (ack) begin
      for (int i = 0; i < N; i++) begin
        if (CW'(i) == ack_code) w_ack_vec[i] = 1'b1;
      end
    end
  end

  assign w_rise         = r_sync[SYNC_STAGES-1] & ~r_prev;
  // A fresh event beats a coincident acknowledge so it is never dropped.
  assign w_pend_raw_nxt = w_rise | (r_pend_raw & ~w_ack_vec);
  assign w_lost_nxt     = (w_rise & r_pend_raw & ~w_ack_vec)
                        | (lost_clr ? '0 : r_lost);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
      r_prev     <= '0;
      r_pend_raw <= '0;
      r_mask     <= '1;
      r_lost     <= '0;
    end else begin
      r_sync[0] <= req_in;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      r_prev     <= r_sync[SYNC_STAGES-1];
      r_pend_raw <= w_pend_raw_nxt;
      r_lost     <= w_lost_nxt;
      if (mask_we) r_mask <= mask_wdata;
    end
  end

  assign pend = r_pend_raw & ~r_mask;
  assign irq  = |pend;
  assign mask = r_mask;
  assign lost = r_lost;

endmodule
`default_nettype wire

// File: tb/tb_irq_pend_latch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_irq_pend_latch                                                    |
// | Directed + random bench against a delay-line reference model.        |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_irq_pend_latch;
  localparam int N  = 8;
  localparam int CW = 3;
  localparam int S  = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_in;
  logic          mask_we;
  logic [N-1:0]  mask_wdata;
  logic          ack;
  logic [CW-1:0] ack_code;
  logic          lost_clr;
  logic [N-1:0]  pend;
  logic          irq;
  logic [N-1:0]  mask;
  logic [N-1:0]  lost;

  int n_checks = 0;
  int n_errors = 0;

  irq_pend_latch #(.N(N), .CW(CW), .SYNC_STAGES(S)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .mask_we(mask_we),
    .mask_wdata(mask_wdata), .ack(ack), .ack_code(ack_code),
    .lost_clr(lost_clr), .pend(pend), .irq(irq), .mask(mask), .lost(lost)
  );

  always #5 clk = ~clk;

  // Reference: m_h[k] is req_in as sampled k+1 edges ago; an event is a
  // 0->1 step in the sampled stream seen S edges late.
  logic [S:0][N-1:0] m_h;
  logic [N-1:0]      m_raw, m_mask, m_lost;

  function automatic logic [N-1:0] ack_bits(input logic a, input logic [CW-1:0] c);
    logic [N-1:0] v = '0;
    if (a && int'(c) < N) v[c] = 1'b1;
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_h    <= '0;
      m_raw  <= '0;
      m_mask <= '1;
      m_lost <= '0;
    end else begin
      m_h   <= {m_h[S-1:0], req_in};
      m_raw <= (m_h[S-1] & ~m_h[S]) | (m_raw & ~ack_bits(ack, ack_code));
      m_lost <= (m_h[S-1] & ~m_h[S] & m_raw & ~ack_bits(ack, ack_code))
              | (lost_clr ? '0 : m_lost);
      if (mask_we) m_mask <= mask_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("pend", 32'(pend), 32'(m_raw & ~m_mask));
    chk("irq",  32'(irq),  32'(|(m_raw & ~m_mask)));
    chk("mask", 32'(mask), 32'(m_mask));
    chk("lost", 32'(lost), 32'(m_lost));
  endtask

  // One clock: edge, then compare #1 later, leaving inputs to be driven.
  task automatic cyc(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      check_model();
      mask_we  = 1'b0;
      ack      = 1'b0;
      lost_clr = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_pend", 32'(pend), 32'h00);
    chk("rst_irq",  32'(irq),  32'h0);
    chk("rst_mask", 32'(mask), 32'hFF);
    chk("rst_lost", 32'(lost), 32'h00);
    cyc(2);
    rst_n = 1'b1;
  endtask

  task automatic wr_mask(input logic [N-1:0] m);
    mask_we = 1'b1; mask_wdata = m; cyc();
  endtask

  task automatic do_ack(input int c);
    ack = 1'b1; ack_code = CW'(c); cyc();
  endtask

  initial begin
    rst_n = 1'b0; req_in = '0; mask_we = 0; mask_wdata = '0;
    ack = 0; ack_code = '0; lost_clr = 0;
    #12;
    do_reset();

    // Basic flow
    wr_mask(8'h00);
    req_in[5] = 1'b1;
    cyc(3);
    chk("basic_pend", 32'(pend), 32'h20);
    chk("basic_irq",  32'(irq),  32'h1);
    do_ack(5);
    chk("basic_ack", 32'(pend), 32'h00);
    req_in[5] = 1'b0;
    cyc(4);

    // Multiple lines
    req_in[1] = 1'b1; req_in[6] = 1'b1;
    cyc(3);
    chk("multi_pend", 32'(pend), 32'h42);
    do_ack(6); chk("multi_ack6", 32'(pend), 32'h02);
    do_ack(1); chk("multi_ack1", 32'(pend), 32'h00);
    do_ack(3); chk("multi_ack3", 32'(pend), 32'h00);
    req_in = '0;
    cyc(4);

    // Masking: latched while masked, exposed once the mask clears
    wr_mask(8'h08);
    req_in[3] = 1'b1; cyc(); req_in[3] = 1'b0;
    cyc(3);
    chk("mask_pend", 32'(pend), 32'h00);
    chk("mask_irq",  32'(irq),  32'h0);
    wr_mask(8'h00);
    chk("unmask_pend", 32'(pend), 32'h08);
    chk("unmask_irq",  32'(irq),  32'h1);
    do_ack(3);
    cyc(2);

    // Collision and lost
    req_in[2] = 1'b1; cyc(); req_in[2] = 1'b0; cyc(4);
    req_in[2] = 1'b1; cyc(); req_in[2] = 1'b0; cyc(4);
    chk("lost_set",  32'(lost), 32'h04);
    chk("lost_pend", 32'(pend), 32'h04);
    req_in[2] = 1'b1; cyc(); req_in[2] = 1'b0; cyc();
    do_ack(2);  // lands on the edge where the new event rises
    chk("rise_ack_pend", 32'(pend), 32'h04);
    chk("rise_ack_lost", 32'(lost), 32'h04);
    lost_clr = 1'b1; cyc();
    chk("lost_clr", 32'(lost), 32'h00);
    do_ack(2);
    cyc(2);

    // Reset mid-traffic with a held request
    req_in[0] = 1'b1; req_in[4] = 1'b1;
    cyc();
    req_in = 8'h01;
    do_reset();
    cyc(3);
    chk("held_masked", 32'(pend), 32'h00);
    wr_mask(8'h00);
    chk("held_pend", 32'(pend), 32'h01);
    do_ack(0);
    cyc(10);
    chk("held_no_reset", 32'(pend), 32'h00);
    req_in = '0;
    cyc(3);

    // Random traffic
    for (int t = 0; t < 2000; t++) begin
      if ($urandom_range(0, 3) == 0) req_in[$urandom_range(0, N-1)] ^= 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        ack = 1'b1; ack_code = CW'($urandom_range(0, N-1));
      end
      if ($urandom_range(0, 15) == 0) begin
        mask_we = 1'b1; mask_wdata = N'($urandom);
      end
      if ($urandom_range(0, 15) == 0) lost_clr = 1'b1;
      if (t == 1000) begin
        rst_n = 1'b0; #1; check_model(); cyc(); rst_n = 1'b1;
      end
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
